// File: rtl/prbs_ber_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prbs_ber_checker                                                |
// | Purpose  : Receive-side PRBS-22 bit-error-rate checker. Self-synchronises  |
// |            a local PRBS-22 generator from decided 2-bit I/Q symbols, then  |
// |            counts bit errors over a fixed measurement window and latches   |
// |            the result. Loses lock after too many errored symbols in a      |
// |            loss window.                                                    |
// | Ports    : clk          - system clock                                     |
// |            reset_n      - asynchronous active-low reset                    |
// |            sam_clk_ena  - symbol strobe, all state advances only when high |
// |            rx_I_sym     - decided I symbol (bit0 = newest PRBS bit)        |
// |            rx_Q_sym     - decided Q symbol                                 |
// |            clear        - synchronous restart to SEARCH, zeroes everything |
// |            locked       - high while in LOCKED                             |
// |            err_cnt      - running bit-error count in the current window    |
// |            meas_err     - error count latched at end of last full window   |
// |            meas_valid   - one-clk pulse when meas_err updates              |
// |            win_cnt      - symbols elapsed in the current window            |
// |            resync_cnt   - saturating count of LOCKED->SEARCH transitions   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module prbs_ber_checker #(
   parameter int LOCK_CNT    = 64,
   parameter int LOSS_WIN    = 256,
   parameter int LOSS_THRESH = 32,
   parameter int MEAS_LEN    = 4194303,
   parameter int ERR_W       = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sam_clk_ena,
   input  logic [1:0]       rx_I_sym,
   input  logic [1:0]       rx_Q_sym,
   input  logic             clear,
   output logic             locked,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] meas_err,
   output logic             meas_valid,
   output logic [21:0]      win_cnt,
   output logic [7:0]       resync_cnt
);

   localparam int         c_MATCH_W   = $clog2(LOCK_CNT + 1);
   localparam int         c_LSYM_W    = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
   localparam int         c_LERR_W    = $clog2(LOSS_THRESH + 1);
   localparam logic [4:0] c_FILL_FULL = 5'd22;

   typedef enum logic [0:0] {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic [21:0]           r_hist;
   logic [21:0]           r_lfsr;
   logic [4:0]            r_fill;
   logic [c_MATCH_W-1:0]  r_match_cnt;
   logic [c_LSYM_W-1:0]   r_loss_sym;
   logic [c_LERR_W-1:0]   r_loss_err;
   logic [ERR_W-1:0]      r_err_cnt;
   logic [ERR_W-1:0]      r_meas_err;
   logic                  r_meas_valid;
   logic [21:0]           r_win_cnt;
   logic [7:0]            r_resync_cnt;

   logic [3:0]            w_rx;
   logic                  w_hist_fb;
   logic                  w_match;
   logic                  w_lock_hit;
   logic [21:0]           w_lfsr_next;
   logic [3:0]            w_diff;
   logic [2:0]            w_err_bits;
   logic                  w_errored;
   logic [ERR_W:0]        w_err_sum;
   logic [ERR_W-1:0]      w_err_sat;
   logic                  w_loss_hit;
   logic                  w_loss_wrap;
   logic                  w_win_end;

   // -------------------------------------------------------------------------
   // Combinational decode: match detection, local LFSR step, error popcount
   // -------------------------------------------------------------------------
   always_comb begin
      w_rx        = {rx_Q_sym, rx_I_sym};

      // H holds the last 22 received newest-bits, i.e. the transmitter
      // register one symbol ago. The new symbol must then be its successor.
      w_hist_fb   = r_hist[21] ^ r_hist[18] ^ r_hist[17] ^ r_hist[16];
      // All-zero history is the LFSR lockup state: a stuck-at-0 input would
      // otherwise satisfy the recurrence trivially.
      w_match     = (r_fill == c_FILL_FULL) && (r_hist != 22'd0) &&
                    (w_rx[0] == w_hist_fb) && (w_rx[3:1] == r_hist[2:0]);
      w_lock_hit  = w_match && (r_match_cnt == c_MATCH_W'(LOCK_CNT - 1));

      w_lfsr_next = {r_lfsr[20:0], r_lfsr[21] ^ r_lfsr[18] ^ r_lfsr[17] ^ r_lfsr[16]};
      w_diff      = w_lfsr_next[3:0] ^ w_rx;
      w_err_bits  = {2'b00, w_diff[0]} + {2'b00, w_diff[1]} +
                    {2'b00, w_diff[2]} + {2'b00, w_diff[3]};
      w_errored   = (w_diff != 4'd0);

      w_err_sum   = {1'b0, r_err_cnt} + (ERR_W + 1)'(w_err_bits);
      w_err_sat   = w_err_sum[ERR_W] ? {ERR_W{1'b1}} : w_err_sum[ERR_W-1:0];

      w_loss_hit  = w_errored && (r_loss_err == c_LERR_W'(LOSS_THRESH - 1));
      w_loss_wrap = (r_loss_sym == c_LSYM_W'(LOSS_WIN - 1));
      w_win_end   = (r_win_cnt == 22'(MEAS_LEN - 1));
   end

   // -------------------------------------------------------------------------
   // FSM: state register and next-state logic
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_SEARCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (clear) begin
         w_state_next = ST_SEARCH;
      end else if (sam_clk_ena) begin
         unique case (r_state)
            ST_SEARCH: if (w_lock_hit) w_state_next = ST_LOCKED;
            ST_LOCKED: if (w_loss_hit) w_state_next = ST_SEARCH;
            default:   w_state_next = ST_SEARCH;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Datapath: history, local generator, counters and measurement latch
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hist       <= 22'd0;
         r_lfsr       <= 22'd0;
         r_fill       <= 5'd0;
         r_match_cnt  <= '0;
         r_loss_sym   <= '0;
         r_loss_err   <= '0;
         r_err_cnt    <= '0;
         r_meas_err   <= '0;
         r_meas_valid <= 1'b0;
         r_win_cnt    <= 22'd0;
         r_resync_cnt <= 8'd0;
      end else if (clear) begin
         r_hist       <= 22'd0;
         r_lfsr       <= 22'd0;
         r_fill       <= 5'd0;
         r_match_cnt  <= '0;
         r_loss_sym   <= '0;
         r_loss_err   <= '0;
         r_err_cnt    <= '0;
         r_meas_err   <= '0;
         r_meas_valid <= 1'b0;
         r_win_cnt    <= 22'd0;
         r_resync_cnt <= 8'd0;
      end else begin
         r_meas_valid <= 1'b0;
         if (sam_clk_ena) begin
            unique case (r_state)
               ST_SEARCH: begin
                  r_hist <= {r_hist[20:0], w_rx[0]};
                  if (r_fill != c_FILL_FULL) begin
                     r_fill <= r_fill + 5'd1;
                  end
                  if (w_match) begin
                     if (w_lock_hit) begin
                        // Seed the local generator with the register state
                        // that produced the symbol just received.
                        r_lfsr      <= {r_hist[20:0], w_rx[0]};
                        r_match_cnt <= '0;
                        r_err_cnt   <= '0;
                        r_win_cnt   <= 22'd0;
                        r_loss_sym  <= '0;
                        r_loss_err  <= '0;
                     end else begin
                        r_match_cnt <= r_match_cnt + c_MATCH_W'(1);
                     end
                  end else begin
                     r_match_cnt <= '0;
                  end
               end

               ST_LOCKED: begin
                  r_lfsr <= w_lfsr_next;
                  if (w_loss_hit) begin
                     // Loss of lock beats a coincident window end: the
                     // partial window is discarded without a report.
                     r_fill      <= 5'd0;
                     r_match_cnt <= '0;
                     r_err_cnt   <= '0;
                     r_win_cnt   <= 22'd0;
                     r_loss_sym  <= '0;
                     r_loss_err  <= '0;
                     if (r_resync_cnt != 8'hFF) begin
                        r_resync_cnt <= r_resync_cnt + 8'd1;
                     end
                  end else begin
                     if (w_win_end) begin
                        r_meas_err   <= w_err_sat;
                        r_meas_valid <= 1'b1;
                        r_err_cnt    <= '0;
                        r_win_cnt    <= 22'd0;
                     end else begin
                        r_err_cnt    <= w_err_sat;
                        r_win_cnt    <= r_win_cnt + 22'd1;
                     end

                     if (w_loss_wrap) begin
                        r_loss_sym <= '0;
                        r_loss_err <= '0;
                     end else begin
                        r_loss_sym <= r_loss_sym + c_LSYM_W'(1);
                        if (w_errored) begin
                           r_loss_err <= r_loss_err + c_LERR_W'(1);
                        end
                     end
                  end
               end

               default: ;
            endcase
         end
      end
   end

   assign locked     = (r_state == ST_LOCKED);
   assign err_cnt    = r_err_cnt;
   assign meas_err   = r_meas_err;
   assign meas_valid = r_meas_valid;
   assign win_cnt    = r_win_cnt;
   assign resync_cnt = r_resync_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_ber_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_prbs_ber_checker                                             |
// | Purpose  : Self-checking bench for prbs_ber_checker. A table of stream     |
// |            segments (length, corruption pattern, idle gap) with expected   |
// |            outputs after each segment, followed by hand-written clear,     |
// |            async reset and stuck-input sequences.                          |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_prbs_ber_checker;

   localparam int c_LOCK_CNT    = 64;
   localparam int c_LOSS_WIN    = 256;
   localparam int c_LOSS_THRESH = 32;
   localparam int c_MEAS_LEN    = 512;
   localparam int c_ERR_W       = 6;
   localparam int c_STROBE_GAP  = 4;

   localparam int c_M_GOOD = 0;   // error-free source symbols
   localparam int c_M_FI0  = 1;   // flip rx_I_sym[0] on selected symbols
   localparam int c_M_FALL = 2;   // flip all four bits on selected symbols
   localparam int c_M_ZERO = 3;   // drive r = 0 on every symbol

   logic               clk;
   logic               reset_n;
   logic               sam_clk_ena;
   logic [1:0]         rx_I_sym;
   logic [1:0]         rx_Q_sym;
   logic               clear;
   logic               locked;
   logic [c_ERR_W-1:0] err_cnt;
   logic [c_ERR_W-1:0] meas_err;
   logic               meas_valid;
   logic [21:0]        win_cnt;
   logic [7:0]         resync_cnt;

   prbs_ber_checker #(
      .LOCK_CNT    (c_LOCK_CNT),
      .LOSS_WIN    (c_LOSS_WIN),
      .LOSS_THRESH (c_LOSS_THRESH),
      .MEAS_LEN    (c_MEAS_LEN),
      .ERR_W       (c_ERR_W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sam_clk_ena (sam_clk_ena),
      .rx_I_sym    (rx_I_sym),
      .rx_Q_sym    (rx_Q_sym),
      .clear       (clear),
      .locked      (locked),
      .err_cnt     (err_cnt),
      .meas_err    (meas_err),
      .meas_valid  (meas_valid),
      .win_cnt     (win_cnt),
      .resync_cnt  (resync_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec    = 0;
   int          n_bad    = 0;
   int          mv_count = 0;
   logic [21:0] src;

   // Counts clocks with meas_valid high, so a stretched pulse also shows up.
   always @(negedge clk) begin
      if (meas_valid === 1'b1) mv_count++;
   end

   typedef struct {
      int   n;          // strobes in the segment
      int   mode;       // corruption pattern
      int   every;      // corrupt one symbol out of every 'every'
      int   idle;       // idle clocks (strobe low, junk on rx) before strobes
      logic exp_locked;
      int   exp_err;
      int   exp_win;
      int   exp_resync;
      int   exp_meas;
      int   exp_mv;     // meas_valid high clocks during the segment
   } seg_t;

   seg_t segs [21];

   function automatic logic [21:0] prbs_step(input logic [21:0] s);
      return {s[20:0], s[21] ^ s[18] ^ s[17] ^ s[16]};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_strobe(input int mode, input logic corrupt);
      logic [3:0] r;
      @(negedge clk);
      src = prbs_step(src);
      r   = src[3:0];
      if (mode == c_M_ZERO)                r = 4'b0000;
      else if (corrupt && mode == c_M_FI0)  r = r ^ 4'b0001;
      else if (corrupt && mode == c_M_FALL) r = r ^ 4'b1111;
      rx_I_sym    = r[1:0];
      rx_Q_sym    = r[3:2];
      sam_clk_ena = 1'b1;
      @(negedge clk);
      sam_clk_ena = 1'b0;
      repeat (c_STROBE_GAP - 2) @(negedge clk);
   endtask

   task automatic run_strobes(input int n, input int mode, input int every);
      for (int i = 0; i < n; i++) begin
         do_strobe(mode, ((i + 1) % every) == 0);
      end
   endtask

   initial begin
      int mv_start;

      // ---------------- segment table (MEAS_LEN=512, ERR_W=6 -> max 63) -----
      //             n    mode      ev  idle lck err  win rsy meas mv
      segs[0]  = '{ 85, c_M_GOOD,  1,  0,  1'b0, 0,   0,  0, 0,  0};  // one short of lock
      segs[1]  = '{  1, c_M_GOOD,  1,  0,  1'b1, 0,   0,  0, 0,  0};  // 86th strobe locks
      segs[2]  = '{511, c_M_GOOD,  1,  0,  1'b1, 0, 511,  0, 0,  0};
      segs[3]  = '{  1, c_M_GOOD,  1,  0,  1'b1, 0,   0,  0, 0,  1};  // clean window end
      segs[4]  = '{100, c_M_FI0,  10,  0,  1'b1, 10, 100, 0, 0,  0};  // 10 x 1 bit
      segs[5]  = '{100, c_M_FALL, 20,  0,  1'b1, 30, 200, 0, 0,  0};  // 5 x 4 bits
      segs[6]  = '{311, c_M_GOOD,  1,  0,  1'b1, 30, 511, 0, 0,  0};
      segs[7]  = '{  1, c_M_GOOD,  1,  0,  1'b1, 0,   0,  0, 30, 1};  // meas_err = 30
      segs[8]  = '{ 60, c_M_FALL,  4,  0,  1'b1, 60,  60, 0, 30, 0};  // 15 x 4 bits
      segs[9]  = '{451, c_M_GOOD,  1,  0,  1'b1, 60, 511, 0, 30, 0};
      segs[10] = '{  1, c_M_FALL,  1,  0,  1'b1, 0,   0,  0, 63, 1};  // 60+4 saturates
      segs[11] = '{225, c_M_GOOD,  1,  0,  1'b1, 0, 225,  0, 63, 0};
      segs[12] = '{ 31, c_M_FALL,  1,  0,  1'b1, 63, 256, 0, 63, 0};  // 31 errored up to loss-window end
      segs[13] = '{ 31, c_M_FALL,  1,  0,  1'b1, 63, 287, 0, 63, 0};  // 31 more in fresh loss window
      segs[14] = '{224, c_M_GOOD,  1,  0,  1'b1, 63, 511, 0, 63, 0};
      segs[15] = '{  1, c_M_FALL,  1,  0,  1'b0, 0,   0,  1, 63, 0};  // 32nd errored on window end: loss wins
      segs[16] = '{ 85, c_M_GOOD,  1,  0,  1'b0, 0,   0,  1, 63, 0};
      segs[17] = '{  1, c_M_GOOD,  1,  0,  1'b1, 0,   0,  1, 63, 0};  // relock after 86
      segs[18] = '{ 50, c_M_GOOD,  1,  0,  1'b1, 0,  50,  1, 63, 0};
      segs[19] = '{  0, c_M_GOOD,  1, 100, 1'b1, 0,  50,  1, 63, 0};  // 100 clk strobe gap: frozen
      segs[20] = '{ 50, c_M_GOOD,  1,  0,  1'b1, 0, 100,  1, 63, 0};  // clean continuation

      // ---------------- reset ------------------------------------------------
      src         = 22'h3fffff;
      reset_n     = 1'b0;
      sam_clk_ena = 1'b0;
      clear       = 1'b0;
      rx_I_sym    = 2'b00;
      rx_Q_sym    = 2'b00;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("reset locked",     int'(locked),     0);
      check("reset err_cnt",    int'(err_cnt),    0);
      check("reset meas_err",   int'(meas_err),   0);
      check("reset win_cnt",    int'(win_cnt),    0);
      check("reset resync_cnt", int'(resync_cnt), 0);
      check("reset meas_valid", int'(meas_valid), 0);

      // ---------------- table-driven segments --------------------------------
      for (int k = 0; k < 21; k++) begin
         mv_start = mv_count;
         for (int j = 0; j < segs[k].idle; j++) begin
            @(negedge clk);
            rx_I_sym = 2'($urandom);
            rx_Q_sym = 2'($urandom);
         end
         run_strobes(segs[k].n, segs[k].mode, segs[k].every);
         check($sformatf("seg%0d locked", k),     int'(locked),        int'(segs[k].exp_locked));
         check($sformatf("seg%0d err_cnt", k),    int'(err_cnt),       segs[k].exp_err);
         check($sformatf("seg%0d win_cnt", k),    int'(win_cnt),       segs[k].exp_win);
         check($sformatf("seg%0d resync_cnt", k), int'(resync_cnt),    segs[k].exp_resync);
         check($sformatf("seg%0d meas_err", k),   int'(meas_err),      segs[k].exp_meas);
         check($sformatf("seg%0d meas_valid", k), mv_count - mv_start, segs[k].exp_mv);
      end

      // ---------------- synchronous clear mid-window -------------------------
      run_strobes(7, c_M_FI0, 1);
      check("pre-clear err_cnt", int'(err_cnt), 7);
      check("pre-clear win_cnt", int'(win_cnt), 107);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear locked",     int'(locked),     0);
      check("clear err_cnt",    int'(err_cnt),    0);
      check("clear meas_err",   int'(meas_err),   0);
      check("clear win_cnt",    int'(win_cnt),    0);
      check("clear resync_cnt", int'(resync_cnt), 0);

      // ---------------- relock, then asynchronous reset between edges --------
      run_strobes(85, c_M_GOOD, 1);
      check("relock-85 locked", int'(locked), 0);
      run_strobes(1, c_M_GOOD, 1);
      check("relock-86 locked", int'(locked), 1);
      run_strobes(7, c_M_FI0, 1);
      check("pre-reset err_cnt", int'(err_cnt), 7);
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("async reset locked",  int'(locked),  0);
      check("async reset err_cnt", int'(err_cnt), 0);
      check("async reset win_cnt", int'(win_cnt), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // ---------------- stuck-at-zero input never locks ----------------------
      mv_start = mv_count;
      run_strobes(200, c_M_ZERO, 1);
      check("stuck locked",     int'(locked),        0);
      check("stuck err_cnt",    int'(err_cnt),       0);
      check("stuck meas_valid", mv_count - mv_start, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/prbs_ber_checker.md
Name: prbs_ber_checker

Overview:
- Receive-side BER checker that sits directly downstream of the PRBS-22 symbol source, after the channel/slicer.
- Consumes decided 2-bit I and Q symbols at the symbol strobe and self-synchronises a local copy of the PRBS-22 generator: feedback = s[21]^s[18]^s[17]^s[16], shift s <= {s[20:0], fb}, I = s[1:0], Q = s[3:2].
- Once locked, counts bit errors over a fixed measurement window and reports the latched result.

Parameters:
- LOCK_CNT, 64, consecutive fully-matching symbols required in SEARCH before declaring lock.
- LOSS_WIN, 256, symbol window for loss-of-lock detection while LOCKED.
- LOSS_THRESH, 32, errored symbols within one LOSS_WIN that force return to SEARCH.
- MEAS_LEN, 4194303, symbols per measurement window (one PRBS-22 period).
- ERR_W, 32, width of error counters.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- sam_clk_ena, in, 1, symbol strobe; all state advances only when high, except clear and reset.
- rx_I_sym, in, 2, decided I symbol; bit0 = newest PRBS bit.
- rx_Q_sym, in, 2, decided Q symbol.
- clear, in, 1, synchronous restart: return to SEARCH and zero all counters and outputs.
- locked, out, 1, high in LOCKED state.
- err_cnt, out, ERR_W, running bit-error count in the current window.
- meas_err, out, ERR_W, bit-error count latched at end of last complete window.
- meas_valid, out, 1, one-clk pulse when meas_err updates.
- win_cnt, out, 22, symbols elapsed in the current window.
- resync_cnt, out, 8, saturating count of LOCKED->SEARCH transitions.

Behaviour:
- Reset: async on reset_n low. State = SEARCH. History H, local LFSR L, and every counter and output reset to 0.
- clear: takes effect at the next clk edge. It has priority over sam_clk_ena and gives the same values as reset, except resync_cnt, which also clears.
- Received word r = {rx_Q_sym, rx_I_sym}, 4 bits. Convention: r = s[3:0] of the transmitter register.

SEARCH, on each sam_clk_ena:
- H <= {H[20:0], r[0]}.
- fill counter increments, saturating at 22.
- Once fill == 22, a symbol matches when both hold:
  - r[0] == H[21]^H[18]^H[17]^H[16] (value before shift);
  - r[3:1] == H[2:0].
- Match: match_cnt++. Mismatch: match_cnt <= 0.
- H == 0 never counts as a match (all-zero lockup guard; stuck-at-0 input never locks).
- When match_cnt reaches LOCK_CNT on a matching symbol:
  - go to LOCKED;
  - L <= {H[20:0], r[0]};
  - zero err_cnt and win_cnt.
- locked rises the clk after the LOCK_CNT-th match.

LOCKED, on each sam_clk_ena:
- Ln = {L[20:0], L[21]^L[18]^L[17]^L[16]}; L <= Ln. L free-runs and never reloads from the input.
- Bit errors e = popcount(Ln[3:0] ^ r), range 0..4.
- err_cnt += e, saturating at all-ones.
- Symbol is errored if e != 0.
- Loss counter counts symbols mod LOSS_WIN; errored-symbol counter counts within that window.
- If the errored count reaches LOSS_THRESH within a window:
  - next state SEARCH;
  - fill and match_cnt cleared;
  - resync_cnt++ (saturating at 255);
  - err_cnt and win_cnt zeroed;
  - no meas_valid.
- Both loss counters clear at each LOSS_WIN boundary.
- win_cnt increments. On the symbol where win_cnt reaches MEAS_LEN-1:
  - meas_err <= err_cnt + e (saturated);
  - meas_valid pulses for exactly 1 clk;
  - err_cnt <= 0, win_cnt <= 0.
- If a loss trigger and window end land on the same symbol, the loss trigger wins: no meas_valid.

Other rules:
- Without sam_clk_ena, all registers hold and meas_valid stays 0.
- meas_err holds its value until the next window completes or reset/clear.
- Input latency is irrelevant because lock is self-synchronising. Output latency: counters reflect a symbol 1 clk after its strobe.

Test Plan:
- Error-free feed: drive the source sequence from seed 22'h3fffff, strobe every 4 clks. Expect locked high after 22+64 = 86 strobes (+1 clk); err_cnt stays 0; after MEAS_LEN more strobes, meas_valid pulses once with meas_err = 0.
- Injected errors: once locked, flip rx_I_sym[0] on 10 symbols and the full r (all 4 bits) on 5 symbols, spread apart. Expect err_cnt = 30, meas_err = 30 at window end, locked stays high.
- Stuck input: hold r = 4'b0000 indefinitely. Expect locked stays 0 and match_cnt never exceeds 0.
- Loss of lock: after lock, feed random symbols. Expect locked to drop within 32 erroneous strobes (inside one LOSS_WIN), resync_cnt = 1, then relock 86 strobes after the correct stream resumes.
- Reset and clear mid-window: while locked with err_cnt = 7, pulse clear. Expect the next clk to show locked = 0, err_cnt = 0, meas_err = 0, resync_cnt = 0. Repeat with reset_n low between edges: outputs go to 0 immediately (async).
- Gapped strobe: sam_clk_ena low for 100 clks mid-window. Expect all counters and L frozen, then correct continuation with no spurious errors.
